// File: rtl/seg_scan_pkg.sv
// Shared state encoding, polarity constants and glyph table for seg_scan_controller.
package seg_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } scan_state_e;

  localparam logic [6:0] SEG_OFF_ACTIVE_HIGH = 7'b0000000;

  // Active-high {g,f,e,d,c,b,a}; entry 0 sits in the low slice, b and d are lowercase glyphs.
  localparam logic [15:0][6:0] SEG_GLYPH = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic int addr_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg_scan_controller_hex_decoder.sv
// Combinational hex value to active-high seven-segment pattern.
module seg_hex_decoder
  import seg_scan_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] pattern
);

  assign pattern = SEG_GLYPH[value];

endmodule

// File: rtl/seg_scan_controller.sv
// Blank/drive scan of NUM_DIGITS common-anode digits through one shared hex decoder.
// Optional build macro SEG_LEADING_ZERO_BLANK_EN suppresses leading zero digits above digit 0.
module seg_scan_controller
  import seg_scan_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int BLANK_CYCLES = 2,
  parameter int DRIVE_CYCLES = 50000,
  parameter int ACTIVE_LOW   = 1,
  localparam int ADDR_W      = addr_width(NUM_DIGITS)
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic                  Enable,
  input  logic                  WrEn,
  input  logic [ADDR_W-1:0]     WrAddr,
  input  logic [3:0]            WrData,
  output logic [NUM_DIGITS-1:0] Anodes,
  output logic [6:0]            Segments,
  output logic                  ScanTick
);

  // state | meaning
  // IDLE  | display dark, waiting for Enable
  // BLANK | all anodes off between digits (ghosting guard)
  // DRIVE | anode of digit idx lit with its glyph

  localparam int CNT_MAX = (BLANK_CYCLES > DRIVE_CYCLES) ? BLANK_CYCLES : DRIVE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0]      BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0]      DRIVE_LAST = CNT_W'(DRIVE_CYCLES - 1);
  localparam logic [ADDR_W-1:0]     IDX_LAST   = ADDR_W'(NUM_DIGITS - 1);
  localparam logic [6:0]            SEG_OFF    = (ACTIVE_LOW != 0) ? ~SEG_OFF_ACTIVE_HIGH
                                                                   : SEG_OFF_ACTIVE_HIGH;
  localparam logic [NUM_DIGITS-1:0] AN_OFF     = (ACTIVE_LOW != 0) ? '1 : '0;

  scan_state_e           state, state_n;
  logic [ADDR_W-1:0]     idx, idx_n;
  logic [CNT_W-1:0]      cnt, cnt_n;
  logic                  wrap_n;
  logic [3:0]            digits [NUM_DIGITS];
  logic [3:0]            cur_value;
  logic [6:0]            cur_glyph;
  logic                  suppress;
  logic                  lit;
  logic [NUM_DIGITS-1:0] anode_on;

  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt;
    wrap_n  = 1'b0;
    if (!Enable) begin
      state_n = ST_IDLE;
      idx_n   = '0;
      cnt_n   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state_n = ST_BLANK;
          idx_n   = '0;
          cnt_n   = '0;
        end
        ST_BLANK: begin
          if (cnt == BLANK_LAST) begin
            state_n = ST_DRIVE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        ST_DRIVE: begin
          if (cnt == DRIVE_LAST) begin
            state_n = ST_BLANK;
            cnt_n   = '0;
            if (idx == IDX_LAST) begin
              idx_n  = '0;
              wrap_n = 1'b1;
            end else begin
              idx_n = idx + ADDR_W'(1);
            end
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        default: begin
          state_n = ST_IDLE;
          idx_n   = '0;
          cnt_n   = '0;
        end
      endcase
    end
  end

  // Outputs are registered from the next-state view so they line up with the state register.
  always_comb begin
    cur_value = 4'h0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_n == ADDR_W'(i)) cur_value = digits[i];
    end
  end

`ifdef SEG_LEADING_ZERO_BLANK_EN
  always_comb begin
    suppress = 1'b0;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      if (idx_n == ADDR_W'(i)) begin
        suppress = 1'b1;
        for (int j = i; j < NUM_DIGITS; j++) begin
          if (digits[j] != 4'h0) suppress = 1'b0;
        end
      end
    end
  end
`else
  assign suppress = 1'b0;
`endif

  assign lit = (state_n == ST_DRIVE) && !suppress;

  always_comb begin
    anode_on = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      anode_on[i] = lit && (idx_n == ADDR_W'(i));
    end
  end

  seg_hex_decoder u_decoder (
    .value   (cur_value),
    .pattern (cur_glyph)
  );

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state    <= ST_IDLE;
      idx      <= '0;
      cnt      <= '0;
      Anodes   <= AN_OFF;
      Segments <= SEG_OFF;
      ScanTick <= 1'b0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      cnt      <= cnt_n;
      Anodes   <= (ACTIVE_LOW != 0) ? ~anode_on : anode_on;
      Segments <= !lit ? SEG_OFF : ((ACTIVE_LOW != 0) ? ~cur_glyph : cur_glyph);
      ScanTick <= wrap_n;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      for (int i = 0; i < NUM_DIGITS; i++) digits[i] <= 4'h0;
    end else if (WrEn) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (WrAddr == ADDR_W'(i)) digits[i] <= WrData;
      end
    end
  end

endmodule
